// File: rtl/uart_cmd_ctrl.sv
// Frame parser (SYNC, ADDR, DATA, CHK) that writes a small register bank; all outputs registered, result one cycle after CHK.
// Optional inter-byte timeout is compiled in by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int          NUM_REGS     = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 208333
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [NUM_REGS*8-1:0] regs_flat_o,
  output logic                  wr_strobe_o,
  output logic [3:0]            wr_addr_o,
  output logic                  err_chk_o,
  output logic                  err_addr_o,
  output logic                  err_timeout_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK} state_e;

  localparam logic [8:0] NREGS = 9'(NUM_REGS);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [3:0] wr_addr_q;
  logic       wr_strobe_q, wr_strobe_d;
  logic       err_chk_q, err_chk_d;
  logic       err_addr_q, err_addr_d;
  logic       err_timeout_q, err_timeout_d;
  logic       busy_q;
  logic       timeout_hit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int             CW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q != IDLE) && !rx_valid_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (rx_valid_i || state_q == IDLE || timeout_hit) cnt_d = '0;
    else if (cnt_q != CNT_MAX)                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CLKS;
  assign timeout_hit          = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (rx_valid_i) begin
      case (state_q)
        IDLE:     if (rx_data_i == SYNC_BYTE) state_d = GET_ADDR;
        GET_ADDR: begin addr_d = rx_data_i; state_d = GET_DATA; end
        GET_DATA: begin data_d = rx_data_i; state_d = GET_CHK;  end
        default:  state_d = IDLE;
      endcase
    end
  end

  // Checksum is judged before the address, so a frame yields at most one error.
  always_comb begin
    wr_strobe_d   = 1'b0;
    err_chk_d     = 1'b0;
    err_addr_d    = 1'b0;
    err_timeout_d = timeout_hit;
    if (rx_valid_i && state_q == GET_CHK) begin
      if (rx_data_i != (addr_q ^ data_q)) err_chk_d   = 1'b1;
      else if ({1'b0, addr_q} >= NREGS)   err_addr_d  = 1'b1;
      else                                wr_strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_addr_q     <= '0;
      wr_strobe_q   <= 1'b0;
      err_chk_q     <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        if (wr_strobe_d && addr_q[3:0] == 4'(k)) regs_q[k] <= data_q;
      if (wr_strobe_d) wr_addr_q <= addr_q[3:0];
      wr_strobe_q   <= wr_strobe_d;
      err_chk_q     <= err_chk_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  always_comb begin
    regs_flat_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_flat_o[8*k +: 8] = regs_q[k];
  end

  assign wr_strobe_o   = wr_strobe_q;
  assign wr_addr_o     = wr_addr_q;
  assign err_chk_o     = err_chk_q;
  assign err_addr_o    = err_addr_q;
  assign err_timeout_o = err_timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frames, errors, noise, back-to-back, timeout (per UART_CMD_TIMEOUT_EN), reset.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] regs_flat;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic        err_chk, err_addr, err_timeout, busy;

  int checks = 0;
  int failures = 0;

  uart_cmd_ctrl #(.NUM_REGS(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(20)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .regs_flat_o(regs_flat), .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr),
    .err_chk_o(err_chk), .err_addr_o(err_addr), .err_timeout_o(err_timeout),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte is held for exactly one cycle; returns 1ns after the edge that sampled it.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    put(8'hA5); put(a); put(d); put(c);
  endtask

  int first_pulse;
  int pulses;

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_regs", regs_flat, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pulses", {28'b0, wr_strobe, err_chk, err_addr, err_timeout}, 32'd0);
    check("rst_wr_addr", {28'b0, wr_addr}, 32'd0);

    put(8'hA5);
    check("busy_after_sync", {31'b0, busy}, 32'd1);
    put(8'h01); put(8'h3C); put(8'h3D);
    check("f1_strobe", {31'b0, wr_strobe}, 32'd1);
    check("f1_wr_addr", {28'b0, wr_addr}, 32'd1);
    check("f1_reg1", {24'b0, regs_flat[15:8]}, 32'h3C);
    check("f1_busy", {31'b0, busy}, 32'd0);
    idle(1);
    check("f1_strobe_1cyc", {31'b0, wr_strobe}, 32'd0);

    frame(8'h00, 8'hFF, 8'hFF);
    check("f2_regs", regs_flat, 32'h0000_3CFF);
    check("f2_wr_addr", {28'b0, wr_addr}, 32'd0);

    frame(8'h02, 8'h10, 8'h00);
    check("badchk_pulses", {28'b0, wr_strobe, err_chk, err_addr, err_timeout}, 32'b0100);
    check("badchk_regs", regs_flat, 32'h0000_3CFF);
    idle(1);
    check("badchk_1cyc", {31'b0, err_chk}, 32'd0);

    frame(8'h02, 8'h10, 8'h12);
    check("f3_regs", regs_flat, 32'h0010_3CFF);
    check("f3_wr_addr", {28'b0, wr_addr}, 32'd2);

    put(8'h00); put(8'h5A);
    check("noise_busy", {31'b0, busy}, 32'd0);
    check("noise_pulses", {28'b0, wr_strobe, err_chk, err_addr, err_timeout}, 32'b0000);
    frame(8'h07, 8'h55, 8'h52);
    check("badaddr_pulses", {28'b0, wr_strobe, err_chk, err_addr, err_timeout}, 32'b0010);
    check("badaddr_regs", regs_flat, 32'h0010_3CFF);
    check("badaddr_wr_addr", {28'b0, wr_addr}, 32'd2);
    idle(1);

    frame(8'h00, 8'hA5, 8'hA5);
    check("sync_payload_regs", regs_flat, 32'h0010_3CA5);
    check("sync_payload_strobe", {31'b0, wr_strobe}, 32'd1);

    frame(8'h03, 8'h77, 8'h74);
    check("b2b_first_strobe", {31'b0, wr_strobe}, 32'd1);
    check("b2b_first_addr", {28'b0, wr_addr}, 32'd3);
    frame(8'h01, 8'h42, 8'h43);
    check("b2b_second_strobe", {31'b0, wr_strobe}, 32'd1);
    check("b2b_regs", regs_flat, 32'h7710_42A5);
    idle(2);

`ifdef UART_CMD_TIMEOUT_EN
    put(8'hA5); put(8'h01);
    first_pulse = -1;
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (err_timeout) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check("tmo_pulse_cycle", first_pulse, 20);
    check("tmo_pulse_count", pulses, 1);
    check("tmo_busy", {31'b0, busy}, 32'd0);
    frame(8'h01, 8'h3C, 8'h3D);
    check("tmo_fresh_frame", regs_flat, 32'h7710_3CA5);
    idle(2);

    put(8'hA5); put(8'h01);
    idle(19);
    put(8'h3C);
    check("expiry_byte_no_tmo", {31'b0, err_timeout}, 32'd0);
    check("expiry_byte_busy", {31'b0, busy}, 32'd1);
    put(8'h3D);
    check("expiry_byte_write", {31'b0, wr_strobe}, 32'd1);
    check("expiry_no_tmo_end", {31'b0, err_timeout}, 32'd0);
`else
    put(8'hA5); put(8'h01);
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (err_timeout) pulses++;
    end
    check("notmo_no_pulse", pulses, 0);
    check("notmo_busy", {31'b0, busy}, 32'd1);
    put(8'h3C); put(8'h3D);
    check("notmo_late_write", {31'b0, wr_strobe}, 32'd1);
    check("notmo_regs", regs_flat, 32'h7710_3CA5);
`endif
    idle(2);

    put(8'hA5); put(8'h01);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_regs", regs_flat, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    put(8'h3C); put(8'h3D);
    check("midrst_tail_pulses", {28'b0, wr_strobe, err_chk, err_addr, err_timeout}, 32'b0000);
    check("midrst_tail_busy", {31'b0, busy}, 32'd0);
    check("midrst_tail_regs", regs_flat, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller behind the 8N1 UART receiver. It consumes the received byte stream (`rx_data`/`rx_valid`) and parses fixed 4-byte write frames: SYNC, ADDR, DATA, CHK. It validates each frame and writes a small register bank that drives board outputs; the LEDs hang off register 0. It is the only sequencer between the UART datapath and the configurable resources.

## Interface
- `NUM_REGS`, 4: number of 8-bit registers, range 1..16.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 208333: maximum allowed gap between bytes inside a frame, in clocks (4 byte-times at 9600 baud, 50 MHz).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the UART receiver; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `regs_flat`  out  NUM_REGS*8  register bank; register k is at bits [8k+7:8k].
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  4  index of the last written register.
- `err_chk`  out  1  one-cycle pulse on checksum mismatch.
- `err_addr`  out  1  one-cycle pulse on good checksum with ADDR ≥ NUM_REGS.
- `err_timeout`  out  1  one-cycle pulse on inter-byte timeout.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK. Transitions happen only on `rx_valid`, except for timeout.
- IDLE:
  - `rx_data == SYNC_BYTE` → GET_ADDR.
  - Any other byte is dropped silently, with no error pulse.
- GET_ADDR: latch ADDR → GET_DATA.
- GET_DATA: latch DATA → GET_CHK.
- GET_CHK: expected CHK = ADDR ^ DATA (8-bit XOR). The next state is always IDLE.
  - If CHK ≠ expected: pulse `err_chk`; no write.
  - Else if ADDR ≥ NUM_REGS: pulse `err_addr`; no write.
  - Else: write DATA to register ADDR[3:0], set `wr_addr` = ADDR[3:0], pulse `wr_strobe`.
- Checksum is evaluated before address. A frame raises at most one error pulse.
- Inside a frame there is no resync. A byte equal to SYNC_BYTE in ADDR, DATA or CHK position is treated as payload.
- Registers hold their value until they are rewritten or reset.

## Timing
- Reset (synchronous, sampled on `posedge clk`):
  - State → IDLE; `regs_flat` = 0, `wr_addr` = 0.
  - All pulses = 0; `busy` = 0; timeout counter = 0.
  - Reset mid-frame discards the partial frame.
- Write latency: the CHK byte with `rx_valid` in cycle N produces the register update and the `wr_strobe`/`err_*` pulse in cycle N+1. `busy` falls in cycle N+1.
- All outputs are registered. The pulses last exactly one cycle.
- Back-to-back bytes (`rx_valid` on consecutive cycles) must be accepted.
- Timeout counter:
  - Cleared on every `rx_valid`.
  - Increments each cycle while state ≠ IDLE.
  - When the counter reaches TIMEOUT_CLKS-1 with no `rx_valid`: state → IDLE next cycle, `err_timeout` pulses, counter clears.
  - If `rx_valid` and the expiry fall in the same cycle, the byte wins: it is processed normally and no timeout occurs.
- Counter width is $clog2(TIMEOUT_CLKS+1); the counter saturates and never wraps.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined: the timeout counter and `err_timeout` logic are present, as described above.
- Not defined: no counter is instantiated and `err_timeout` is tied to 0. A partial frame waits in its state indefinitely until bytes arrive or `rst` is asserted.

## Test plan
- Reset, then send A5 01 3C 3D → `regs_flat[15:8]` = 8'h3C one cycle after the last `rx_valid`; `wr_strobe` for 1 cycle with `wr_addr` = 1; `busy` = 0 afterwards. Send A5 00 FF FF → `regs_flat[7:0]` = FF.
- Bad checksum A5 02 10 00 → `err_chk` pulse; `regs_flat` unchanged; no `wr_strobe`. A following good frame A5 02 10 12 writes register 2 = 8'h10.
- Address out of range, NUM_REGS=4: A5 07 55 52 → `err_addr` pulse only, no write. Noise bytes 00 5A before A5 in IDLE → ignored, no error pulse.
- Payload equals SYNC: A5 00 A5 A5 → register 0 = A5 (no resync). Back-to-back frames with `rx_valid` every cycle → both writes land.
- Timeout, with the macro defined and TIMEOUT_CLKS=20: send A5 01, then idle for 20 cycles → `err_timeout` pulses once; `busy` = 0; the next A5 starts a fresh frame. `rx_valid` exactly on the expiry cycle → byte accepted, no timeout. Without the macro: the same stimulus leaves `busy` = 1 and completes when 3C 3D arrive later.
- Assert `rst` for one cycle after A5 01 → state IDLE and `regs_flat` = 0. The remaining 3C 3D bytes are ignored as noise.
